uart_rx_ctl: RTL and testbench

UART receiver, the counterpart of the UART transmitter in the UART_controller block. Deserialises 8N1 frames from the rxd line into bytes, using 16x oversampling with a mid-bit sample point. Presents each received byte with a ready flag plus framing-error and overrun status to the host logic. Sits between the board RX pin and the controller's command/data path.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 40 ++++
 rtl/uart_rx_ctl.sv | 158 +++++++++++++++
 tb/tb_uart_rx_ctl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame constants and the baud divider
// helper. The transmitter uses the same package.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } uart_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   DATA_BITS  = 8;
    localparam int   OVERSAMPLE = 16;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        return (clk_freq + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock pulse every DIV clocks. clr restarts the
// count so the first tick lands exactly DIV clocks later (tie low if unused).
module uart_baud_tick #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    import uart_pkg::*;

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: wrap at DIV-1, forced to zero on clr.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_MAX) && !clr;

endmodule

// File: rtl/uart_rx_ctl.sv
// 8N1 UART receiver with 16x oversampling and mid-bit sampling. Presents each
// byte with a ready flag, a one-cycle framing-error pulse and a sticky overrun.
module uart_rx_ctl #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rd,
    output logic [7:0] data,
    output logic       rx_rdy,
    output logic       frame_err,
    output logic       overrun
);
    import uart_pkg::*;

    // Sample points within a bit: mid-bit for the start bit, then every full bit.
    localparam logic [3:0] S_MID  = 4'(uart_pkg::OVERSAMPLE / 2 - 1);
    localparam logic [3:0] S_LAST = 4'(uart_pkg::OVERSAMPLE - 1);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    uart_state_e state_q, state_d;

    logic       rxd_meta_q, rxs_q;
    logic [3:0] s_q, s_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       rx_rdy_q, rx_rdy_d;
    logic       overrun_q, overrun_d;
    logic       frame_err_q, frame_err_d;

    logic tick;
    logic clr_tick, mid_sample, bit_sample, stop_sample;
    logic byte_done, stop_bad;

    uart_baud_tick #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_tick),
        .tick (tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (rxs_q == START_BIT) state_d = START;
            START: if (tick && (s_q == S_MID))
                       state_d = (rxs_q == START_BIT) ? DATA : IDLE;
            DATA:  if (tick && (s_q == S_LAST) && (bit_q == BIT_LAST))
                       state_d = STOP;
            STOP:  if (tick && (s_q == S_LAST))
                       state_d = (rxs_q == STOP_BIT) ? IDLE : BRK;
            BRK:   if (rxs_q == STOP_BIT) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM strobes: tick alignment and the sample points.
    always_comb begin
        clr_tick    = (state_q == IDLE) && (rxs_q == START_BIT);
        mid_sample  = (state_q == START) && tick && (s_q == S_MID);
        bit_sample  = (state_q == DATA) && tick && (s_q == S_LAST);
        stop_sample = (state_q == STOP) && tick && (s_q == S_LAST);
        byte_done   = stop_sample && (rxs_q == STOP_BIT);
        stop_bad    = stop_sample && (rxs_q != STOP_BIT);
    end

    // Datapath next values: counters, shift register and host-side status.
    always_comb begin
        s_d         = s_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        data_d      = data_q;
        rx_rdy_d    = rx_rdy_q;
        overrun_d   = overrun_q;
        frame_err_d = stop_bad;

        // Restarting s at the start-bit midpoint keeps later samples mid-bit.
        if ((state_q == IDLE) || mid_sample) begin
            s_d = '0;
        end else if (tick) begin
            s_d = s_q + 1'b1;
        end

        if (state_q != DATA) begin
            bit_d = '0;
        end else if (bit_sample) begin
            bit_d = bit_q + 1'b1;
        end

        // LSB arrives first, so shift right with new bits entering at the MSB.
        if (bit_sample) begin
            shift_d = {rxs_q, shift_q[7:1]};
        end

        if (rd && rx_rdy_q) begin
            rx_rdy_d  = 1'b0;
            overrun_d = 1'b0;
        end

        // A new byte always wins; it only counts as overrun if nobody read the old one.
        if (byte_done) begin
            data_d   = shift_q;
            rx_rdy_d = 1'b1;
            if (rx_rdy_q && !rd) begin
                overrun_d = 1'b1;
            end
        end
    end

    // Synchroniser and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q  <= 1'b1;
            rxs_q       <= 1'b1;
            s_q         <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            rx_rdy_q    <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rxd_meta_q  <= rxd;
            rxs_q       <= rxd_meta_q;
            s_q         <= s_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            rx_rdy_q    <= rx_rdy_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data      = data_q;
    assign rx_rdy    = rx_rdy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctl.sv
// Scoreboard bench for uart_rx_ctl: stimulus tasks push the expected host-side
// events, a monitor pops and compares whenever the DUT status changes.
module tb_uart_rx_ctl;

    localparam int BAUD     = 115200;
    localparam int CLK_FREQ = 4 * 16 * BAUD;   // DIV = 4, 64 clocks per bit
    localparam int BIT      = 64;
    // Clocks from driving the start edge (at a negedge) to the negedge just
    // before the edge that latches the byte: 2 sync clocks + 1 start detect
    // + 152 ticks of 4 clocks to the stop midpoint, minus one.
    localparam int DONE_NEG = 2 + 1 + 152 * 4 - 1;

    localparam int EV_BYTE = 0;
    localparam int EV_FERR = 1;
    localparam int EV_CLR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] d;
        logic       rdy;
        logic       ovr;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       rd;
    logic [7:0] data;
    logic       rx_rdy;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    ev_t exp_q[$];

    // Reference model of what the host should see.
    bit         m_unread = 1'b0;
    bit         m_ovr    = 1'b0;
    logic [7:0] m_cur    = 8'h00;

    uart_rx_ctl #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rd        (rd),
        .data      (data),
        .rx_rdy    (rx_rdy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input logic [7:0] d, input logic rdy, input logic ovr);
        ev_t e;
        e.kind = kind;
        e.d    = d;
        e.rdy  = rdy;
        e.ovr  = ovr;
        exp_q.push_back(e);
    endtask

    // Monitor side: compare one observed event against the head of the queue.
    task automatic take(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d data %02h expected no event", kind, data);
        end else begin
            e = exp_q.pop_front();
            $display("txn kind=%0d data=%02h rdy=%0d ovr=%0d (exp kind=%0d data=%02h)",
                     kind, data, rx_rdy, overrun, e.kind, e.d);
            chk("event_kind", kind, e.kind);
            chk("event_data", data, e.d);
            chk("event_rdy", rx_rdy, e.rdy);
            chk("event_overrun", overrun, e.ovr);
        end
    endtask

    logic [7:0] p_data = 8'h00;
    logic       p_rdy  = 1'b0;
    logic       p_ovr  = 1'b0;

    // Monitor: sample just after each rising edge, classify status changes.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst !== 1'b0) begin
                p_data = data;
                p_rdy  = rx_rdy;
                p_ovr  = overrun;
            end else begin
                if (frame_err === 1'b1) take(EV_FERR);
                if (rx_rdy === 1'b1 && (!p_rdy || data !== p_data || (overrun && !p_ovr)))
                    take(EV_BYTE);
                else if (rx_rdy === 1'b0 && p_rdy)
                    take(EV_CLR);
                p_data = data;
                p_rdy  = rx_rdy;
                p_ovr  = overrun;
            end
        end
    end

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (BIT) @(negedge clk);
    endtask

    // Send one 8N1 frame; optionally pulse rd in the cycle the byte completes.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit rd_now);
        if (stop_ok) begin
            m_ovr    = m_unread && !rd_now;
            m_unread = 1'b1;
            m_cur    = b;
            push_ev(EV_BYTE, b, 1'b1, m_ovr);
        end else begin
            push_ev(EV_FERR, m_cur, m_unread, m_ovr);
        end
        fork
            begin
                drive_bit(1'b0);
                for (int i = 0; i < 8; i++) drive_bit(b[i]);
                drive_bit(stop_ok ? 1'b1 : 1'b0);
            end
            begin
                if (rd_now) begin
                    repeat (DONE_NEG) @(negedge clk);
                    rd = 1'b1;
                    @(negedge clk);
                    rd = 1'b0;
                end
            end
        join
    endtask

    task automatic do_rd();
        bit was_unread;
        was_unread = m_unread;
        if (m_unread) begin
            push_ev(EV_CLR, m_cur, 1'b0, 1'b0);
            m_unread = 1'b0;
            m_ovr    = 1'b0;
        end
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        if (was_unread) chk("rd_clears_rdy", rx_rdy, 1'b0);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] rb;
        int         kind;

        rxd = 1'b1;
        rd  = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        chk("reset_data", data, 8'h00);
        chk("reset_rdy", rx_rdy, 1'b0);
        chk("reset_ferr", frame_err, 1'b0);
        chk("reset_ovr", overrun, 1'b0);
        idle(2 * BIT);

        // Plain frame, then acknowledge.
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(BIT);
        do_rd();

        // Short low glitch must be rejected without any flag.
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        idle(3 * BIT);
        chk("glitch_rdy", rx_rdy, 1'b0);
        chk("glitch_data", data, 8'hA5);

        // Bad stop bit, line held low, then a good frame after release.
        send_frame(8'h3C, 1'b0, 1'b0);
        rxd = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        idle(BIT);
        send_frame(8'h55, 1'b1, 1'b0);
        idle(BIT);
        do_rd();

        // Two frames without reading: overrun.
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(BIT);
        do_rd();

        // Read coinciding with completion of the second byte.
        send_frame(8'h33, 1'b1, 1'b0);
        send_frame(8'h44, 1'b1, 1'b1);
        idle(BIT);
        do_rd();

        // Reset in the middle of data bit 4.
        b = 8'h96;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rxd = b[4];
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_unread = 1'b0;
        m_ovr    = 1'b0;
        m_cur    = 8'h00;
        chk("midreset_data", data, 8'h00);
        chk("midreset_rdy", rx_rdy, 1'b0);
        chk("midreset_ferr", frame_err, 1'b0);
        chk("midreset_ovr", overrun, 1'b0);
        idle(2 * BIT);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(BIT);
        do_rd();

        // Randomised frames, read timing and framing errors.
        for (int n = 0; n < 16; n++) begin
            rb = 8'($urandom);
            while (rb == m_cur) rb = 8'($urandom);
            kind = $urandom_range(0, 7);
            if (kind == 0) begin
                send_frame(rb, 1'b0, 1'b0);
                rxd = 1'b0;
                repeat (BIT) @(negedge clk);
                idle(BIT);
            end else begin
                send_frame(rb, 1'b1, kind == 1);
                idle($urandom_range(0, 64));
                if ($urandom_range(0, 2) == 0) do_rd();
            end
        end

        idle(200);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
